// File: rtl/axi_lite_if_gpio_if.sv
// AXI-Lite bus bundle between the MMIO bus master and the GPIO register slave.
// Every channel transfers on a rising edge where its VALID and READY are both 1.
interface axi_lite_if_gpio_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_if_gpio.sv
// AXI-Lite slave with two GPIO registers (DATA @0x0, DIR @0x4) mirrored onto pins.
// AW and W are accepted independently and the write commits once both are present.
module axi_lite_if_gpio #(
  parameter int                 ADDR_W      = 32,
  parameter int                 DATA_W      = 32,
  parameter logic [DATA_W-1:0]  DECERR_DATA = 32'hDEADBEEF
) (
  input  logic              ACLK,
  input  logic              ARESET,
  axi_lite_if_gpio_if.slave bus,
  output logic [DATA_W-1:0] gpio_out,
  output logic [DATA_W-1:0] gpio_dir
);

  localparam int NB = DATA_W / 8;

  logic              aw_held;
  logic [3:0]        aw_addr_q;
  logic              w_held;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     wstrb_q;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] dir_reg;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_strb;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_resp;

  // Only the low nibble of each address is decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.AWADDR[ADDR_W-1:4], bus.ARADDR[ADDR_W-1:4]};

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [NB-1:0]     strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < NB; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    aw_hs   = bus.AWVALID && bus.AWREADY;
    w_hs    = bus.WVALID && bus.WREADY;
    ar_hs   = bus.ARVALID && bus.ARREADY;
    commit  = (aw_held || aw_hs) && (w_held || w_hs);
    wr_addr = aw_held ? aw_addr_q : bus.AWADDR[3:0];
    wr_data = w_held ? wdata_q : bus.WDATA;
    wr_strb = w_held ? wstrb_q : bus.WSTRB;
    rd_data = DECERR_DATA;
    rd_resp = 2'b11;
    case (bus.ARADDR[3:0])
      4'h0: begin rd_data = data_reg; rd_resp = 2'b00; end
      4'h4: begin rd_data = dir_reg;  rd_resp = 2'b00; end
      default: ;
    endcase
  end

  // Write path: one outstanding write, readies gated while a response is pending.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bus.AWREADY <= 1'b0;
      bus.WREADY  <= 1'b0;
      bus.BVALID  <= 1'b0;
      bus.BRESP   <= 2'b00;
      aw_held     <= 1'b0;
      aw_addr_q   <= '0;
      w_held      <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      data_reg    <= '0;
      dir_reg     <= '0;
    end else begin
      bus.AWREADY <= bus.AWVALID && !bus.AWREADY && !aw_held && !bus.BVALID;
      bus.WREADY  <= bus.WVALID && !bus.WREADY && !w_held && !bus.BVALID;

      if (bus.BVALID && bus.BREADY) bus.BVALID <= 1'b0;

      if (commit) begin
        aw_held    <= 1'b0;
        w_held     <= 1'b0;
        bus.BVALID <= 1'b1;
        bus.BRESP  <= 2'b00;
        case (wr_addr)
          4'h0: data_reg <= merge_bytes(data_reg, wr_data, wr_strb);
          4'h4: dir_reg  <= merge_bytes(dir_reg, wr_data, wr_strb);
          default: ;
        endcase
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= bus.AWADDR[3:0];
        end
        if (w_hs) begin
          w_held  <= 1'b1;
          wdata_q <= bus.WDATA;
          wstrb_q <= bus.WSTRB;
        end
      end
    end
  end

  // Read path: RDATA keeps its last value after the R handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bus.ARREADY <= 1'b0;
      bus.RVALID  <= 1'b0;
      bus.RDATA   <= '0;
      bus.RRESP   <= 2'b00;
    end else begin
      bus.ARREADY <= bus.ARVALID && !bus.ARREADY && !bus.RVALID;
      if (ar_hs) begin
        bus.RVALID <= 1'b1;
        bus.RDATA  <= rd_data;
        bus.RRESP  <= rd_resp;
      end else if (bus.RVALID && bus.RREADY) begin
        bus.RVALID <= 1'b0;
        bus.RRESP  <= 2'b00;
      end
    end
  end

  assign gpio_out = data_reg;
  assign gpio_dir = dir_reg;

endmodule

// File: tb/tb_axi_lite_if_gpio.sv
// Directed bench for axi_lite_if_gpio: a table of register accesses with hand-computed
// results, followed by hand-written handshake, back-pressure and reset sequences.
module tb_axi_lite_if_gpio;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] gpio_out;
  logic [31:0] gpio_dir;

  axi_lite_if_gpio_if bus ();

  axi_lite_if_gpio dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .bus      (bus),
    .gpio_out (gpio_out),
    .gpio_dir (gpio_dir)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [31:0] exp_out;
    logic [31:0] exp_dir;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_d, input int w_d);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_now;
    bit w_now;
    bus.AWADDR = a;
    bus.WDATA  = d;
    bus.WSTRB  = s;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      if (!aw_done && c >= aw_d) bus.AWVALID = 1'b1;
      if (!w_done && c >= w_d) bus.WVALID = 1'b1;
      aw_now = bus.AWVALID && bus.AWREADY;
      w_now  = bus.WVALID && bus.WREADY;
      tick();
      if (aw_now) begin bus.AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_now)  begin bus.WVALID  = 1'b0; w_done  = 1'b1; end
    end
    check("aw_handshake_done", {31'd0, aw_done}, 32'd1);
    check("w_handshake_done", {31'd0, w_done}, 32'd1);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    bit seen = 1'b0;
    resp = 2'bxx;
    bus.BREADY = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.BVALID) begin
        seen = 1'b1;
        resp = bus.BRESP;
      end
      tick();
    end
    check("bvalid_seen", {31'd0, seen}, 32'd1);
    check("bvalid_one_cycle", {31'd0, bus.BVALID}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ar_done = 1'b0;
    bit seen = 1'b0;
    bit ar_now;
    d = 'x;
    resp = 2'bxx;
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    bus.RREADY  = 1'b1;
    for (int c = 0; c < 20 && !ar_done; c++) begin
      ar_now = bus.ARVALID && bus.ARREADY;
      tick();
      if (ar_now) begin bus.ARVALID = 1'b0; ar_done = 1'b1; end
    end
    bus.ARVALID = 1'b0;
    check("ar_handshake_done", {31'd0, ar_done}, 32'd1);
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.RVALID) begin
        seen = 1'b1;
        d    = bus.RDATA;
        resp = bus.RRESP;
      end
      tick();
    end
    check("rvalid_seen", {31'd0, seen}, 32'd1);
    check("rvalid_cleared", {31'd0, bus.RVALID}, 32'd0);
    check("rresp_cleared", {30'd0, bus.RRESP}, 32'd0);
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;
  logic [31:0] held_rdata;

  initial begin
    vecs[0]  = '{1'b1, 32'h0,   32'h1234_5678, 4'hF, 32'h0,         2'b00, 32'h1234_5678, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,   32'h0,         4'h0, 32'h1234_5678, 2'b00, 32'h1234_5678, 32'h0};
    vecs[2]  = '{1'b1, 32'h4,   32'h0000_00FF, 4'hF, 32'h0,         2'b00, 32'h1234_5678, 32'hFF};
    vecs[3]  = '{1'b0, 32'h4,   32'h0,         4'h0, 32'h0000_00FF, 2'b00, 32'h1234_5678, 32'hFF};
    vecs[4]  = '{1'b0, 32'h0,   32'h0,         4'h0, 32'h1234_5678, 2'b00, 32'h1234_5678, 32'hFF};
    vecs[5]  = '{1'b0, 32'h8,   32'h0,         4'h0, 32'hDEAD_BEEF, 2'b11, 32'h1234_5678, 32'hFF};
    vecs[6]  = '{1'b0, 32'h0,   32'h0,         4'h0, 32'h1234_5678, 2'b00, 32'h1234_5678, 32'hFF};
    vecs[7]  = '{1'b1, 32'h0,   32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00, 32'hFFFF_FFFF, 32'hFF};
    vecs[8]  = '{1'b1, 32'h0,   32'h0000_0000, 4'h3, 32'h0,         2'b00, 32'hFFFF_0000, 32'hFF};
    vecs[9]  = '{1'b0, 32'h0,   32'h0,         4'h0, 32'hFFFF_0000, 2'b00, 32'hFFFF_0000, 32'hFF};
    vecs[10] = '{1'b1, 32'hC,   32'hAAAA_AAAA, 4'hF, 32'h0,         2'b00, 32'hFFFF_0000, 32'hFF};
    vecs[11] = '{1'b0, 32'h4,   32'h0,         4'h0, 32'h0000_00FF, 2'b00, 32'hFFFF_0000, 32'hFF};
    vecs[12] = '{1'b1, 32'h4,   32'h1234_0000, 4'hC, 32'h0,         2'b00, 32'hFFFF_0000, 32'h1234_00FF};
    vecs[13] = '{1'b0, 32'hC,   32'h0,         4'h0, 32'hDEAD_BEEF, 2'b11, 32'hFFFF_0000, 32'h1234_00FF};
    vecs[14] = '{1'b0, 32'h104, 32'h0,         4'h0, 32'h1234_00FF, 2'b00, 32'hFFFF_0000, 32'h1234_00FF};
    vecs[15] = '{1'b1, 32'h100, 32'h0000_00A5, 4'h1, 32'h0,         2'b00, 32'hFFFF_00A5, 32'h1234_00FF};

    ARESET = 1'b1;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    tick();
    tick();
    ARESET = 1'b0;
    check("reset_awready", {31'd0, bus.AWREADY}, 32'd0);
    check("reset_wready", {31'd0, bus.WREADY}, 32'd0);
    check("reset_bvalid", {31'd0, bus.BVALID}, 32'd0);
    check("reset_arready", {31'd0, bus.ARREADY}, 32'd0);
    check("reset_rvalid", {31'd0, bus.RVALID}, 32'd0);
    check("reset_rdata", bus.RDATA, 32'h0);
    check("reset_gpio_out", gpio_out, 32'h0);
    check("reset_gpio_dir", gpio_dir, 32'h0);

    // Simultaneous AW/W: ready pulses after edge 1, commit at edge 2.
    bus.BREADY = 1'b0;
    bus.AWADDR = 32'h0; bus.WDATA = 32'h0BAD_F00D; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    tick();
    check("sim_awready_c1", {31'd0, bus.AWREADY}, 32'd1);
    check("sim_wready_c1", {31'd0, bus.WREADY}, 32'd1);
    check("sim_bvalid_c1", {31'd0, bus.BVALID}, 32'd0);
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("sim_bvalid_c2", {31'd0, bus.BVALID}, 32'd1);
    check("sim_bresp_c2", {30'd0, bus.BRESP}, 32'd0);
    check("sim_awready_c2", {31'd0, bus.AWREADY}, 32'd0);
    check("sim_gpio_out", gpio_out, 32'h0BAD_F00D);
    bus.BREADY = 1'b1;
    tick();
    check("sim_bvalid_clear", {31'd0, bus.BVALID}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        issue_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0);
        wait_b(rsp);
        check($sformatf("vec%0d_bresp", i), {30'd0, rsp}, {30'd0, vecs[i].exp_resp});
      end else begin
        do_read(vecs[i].addr, rd, rsp);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        check($sformatf("vec%0d_rresp", i), {30'd0, rsp}, {30'd0, vecs[i].exp_resp});
      end
      check($sformatf("vec%0d_gpio_out", i), gpio_out, vecs[i].exp_out);
      check($sformatf("vec%0d_gpio_dir", i), gpio_dir, vecs[i].exp_dir);
    end

    // B back-pressure: response held, no new address/data accepted.
    bus.BREADY = 1'b0;
    issue_write(32'h4, 32'h0000_0F0F, 4'hF, 0, 0);
    bus.AWADDR = 32'h0; bus.WDATA = 32'h1111_1111;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bhold%0d_bvalid", c), {31'd0, bus.BVALID}, 32'd1);
      check($sformatf("bhold%0d_awready", c), {31'd0, bus.AWREADY}, 32'd0);
      check($sformatf("bhold%0d_wready", c), {31'd0, bus.WREADY}, 32'd0);
      tick();
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1;
    tick();
    check("bhold_release", {31'd0, bus.BVALID}, 32'd0);
    check("bhold_gpio_dir", gpio_dir, 32'h0000_0F0F);
    check("bhold_gpio_out", gpio_out, 32'hFFFF_00A5);

    // R back-pressure: RDATA/RVALID stable, no new AR accepted.
    bus.RREADY = 1'b0;
    bus.ARADDR = 32'h0; bus.ARVALID = 1'b1;
    tick();
    tick();
    bus.ARADDR = 32'h4;
    check("rhold_rvalid_start", {31'd0, bus.RVALID}, 32'd1);
    held_rdata = bus.RDATA;
    check("rhold_rdata_start", held_rdata, 32'hFFFF_00A5);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("rhold%0d_rvalid", c), {31'd0, bus.RVALID}, 32'd1);
      check($sformatf("rhold%0d_rdata", c), bus.RDATA, 32'hFFFF_00A5);
      check($sformatf("rhold%0d_arready", c), {31'd0, bus.ARREADY}, 32'd0);
    end
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    tick();
    check("rhold_release", {31'd0, bus.RVALID}, 32'd0);
    check("rhold_rresp_clear", {30'd0, bus.RRESP}, 32'd0);
    check("rhold_rdata_kept", bus.RDATA, 32'hFFFF_00A5);

    // AW leads W by 3 cycles, then W leads AW.
    issue_write(32'h0, 32'hCAFE_0001, 4'hF, 0, 3);
    wait_b(rsp);
    check("aw_first_bresp", {30'd0, rsp}, 32'd0);
    tick();
    check("aw_first_single_commit", {31'd0, bus.BVALID}, 32'd0);
    check("aw_first_gpio_out", gpio_out, 32'hCAFE_0001);
    issue_write(32'h4, 32'h0000_5A5A, 4'h3, 4, 0);
    wait_b(rsp);
    check("w_first_bresp", {30'd0, rsp}, 32'd0);
    do_read(32'h4, rd, rsp);
    check("w_first_rdata", rd, 32'h0000_5A5A);

    // Reset in the middle of a write: AW held, W arrives with reset.
    bus.AWADDR = 32'h0; bus.AWVALID = 1'b1;
    for (int c = 0; c < 10 && !(bus.AWVALID && bus.AWREADY); c++) tick();
    check("mid_aw_ready", {31'd0, bus.AWREADY}, 32'd1);
    tick();
    bus.AWVALID = 1'b0;
    bus.WDATA = 32'h7777_7777; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    ARESET = 1'b1;
    tick();
    tick();
    ARESET = 1'b0;
    bus.WVALID = 1'b0;
    check("mid_rst_gpio_out", gpio_out, 32'h0);
    check("mid_rst_gpio_dir", gpio_dir, 32'h0);
    check("mid_rst_bvalid", {31'd0, bus.BVALID}, 32'd0);
    check("mid_rst_awready", {31'd0, bus.AWREADY}, 32'd0);
    check("mid_rst_wready", {31'd0, bus.WREADY}, 32'd0);
    check("mid_rst_rdata", bus.RDATA, 32'h0);
    tick();
    check("mid_rst_no_commit", {31'd0, bus.BVALID}, 32'd0);
    do_read(32'h0, rd, rsp);
    check("mid_rst_read_data", rd, 32'h0);
    do_read(32'h4, rd, rsp);
    check("mid_rst_read_dir", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
